// File: rtl/pe_array_ctrl.sv
// -----------------------------------------------------------------------------
// pe_array_ctrl
//   Sequencer for a K x K array of PE cells (pixel DFF + weight DFF + multiplier).
//   For each layer pass it clears the PE weight registers and loads K*K weights.
//   It then streams a raster-order feature map through the array. It drives the
//   shared 4:1 pixel-mux select and flags every cycle in which the adder-tree
//   output carries the products of a complete window.
//
//   Optional feature: define PE_CTRL_PERF_EN to add the stall_cnt output, a
//   saturating count of STREAM cycles with px_valid low.
//
// Parameters
//   K_MAX     largest kernel side accepted on cfg_k
//   DIM_W     width of image dimensions and row/col counters
//   PIPE_LAT  cycles from pixel handshake to product valid (>= 1)
//
// Ports
//   CLK, RST     clock; synchronous active-high reset
//   start        begin a pass (IDLE only); cfg_k/cfg_w/cfg_h latched then
//   abort        synchronous return to IDLE, overrides everything but RST
//   cfg_k/w/h    kernel side, image width, image height
//   busy         high in every state except IDLE
//   done         1-cycle pulse at end of pass
//   cfg_err      1-cycle pulse, cycle after a start with an unusable config
//   pe_rst_w     clears all PE weight registers
//   w_ld, w_idx  weight-load strobe and row-major PE index
//   px_valid     feature pixel available
//   px_ready     pixel accepted (STREAM only)
//   pe_sel       PE mux: 0 HOLD, 1 SHIFT, 2 LOAD, 3 WRAP
//   win_valid    complete window at adder-tree output
//   win_row/col  output coordinates of that window
//   stall_cnt    (PE_CTRL_PERF_EN only) STREAM cycles with px_valid low
// -----------------------------------------------------------------------------
module pe_array_ctrl #(
   parameter int unsigned K_MAX    = 5,
   parameter int unsigned DIM_W    = 7,
   parameter int unsigned PIPE_LAT = 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  logic             abort,
   input  logic [2:0]       cfg_k,
   input  logic [DIM_W-1:0] cfg_w,
   input  logic [DIM_W-1:0] cfg_h,
   output logic             busy,
   output logic             done,
   output logic             cfg_err,
   output logic             pe_rst_w,
   output logic             w_ld,
   output logic [4:0]       w_idx,
   input  logic             px_valid,
   output logic             px_ready,
   output logic [1:0]       pe_sel,
   output logic             win_valid,
   output logic [DIM_W-1:0] win_row,
`ifdef PE_CTRL_PERF_EN
   output logic [DIM_W-1:0] win_col,
   output logic [15:0]      stall_cnt
`else
   output logic [DIM_W-1:0] win_col
`endif
);

   localparam logic [1:0] SEL_HOLD  = 2'd0;
   localparam logic [1:0] SEL_SHIFT = 2'd1;
   localparam logic [1:0] SEL_LOAD  = 2'd2;
   localparam logic [1:0] SEL_WRAP  = 2'd3;

   localparam int unsigned DCW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT + 1) : 1;

   typedef enum logic [2:0] {
      StIdle,
      StWclr,
      StWload,
      StStream,
      StDrain,
      StDone
   } state_t;

   state_t state, state_next;

   // Latched configuration for the running pass
   logic [2:0]       k_reg;
   logic [DIM_W-1:0] w_reg;
   logic [DIM_W-1:0] h_reg;

   // Raster position of the next pixel to be accepted
   logic [DIM_W-1:0] row;
   logic [DIM_W-1:0] col;

   logic [4:0]       widx;
   logic [DCW-1:0]   drain_cnt;
   logic             cfg_err_reg;

   // Window-flag delay line, aligned with the PE/multiplier pipeline
   logic             dly_v   [PIPE_LAT];
   logic [DIM_W-1:0] dly_row [PIPE_LAT];
   logic [DIM_W-1:0] dly_col [PIPE_LAT];

`ifdef PE_CTRL_PERF_EN
   logic [15:0]      stall_reg;
`endif

   // ---------------------------------------------------------------------------
   // Configuration check and derived values
   // ---------------------------------------------------------------------------
   logic [DIM_W-1:0] k_in_ext;
   logic [DIM_W-1:0] k_reg_ext;
   logic [DIM_W-1:0] k_m1;
   logic [5:0]       kk;
   logic             cfg_ok;
   logic             accept;
   logic             hs;
   logic             last_col;
   logic             last_px;
   logic             win_ok;
   logic             wload_end;
   logic             drain_end;

   always_comb begin
      k_in_ext  = DIM_W'(cfg_k);
      k_reg_ext = DIM_W'(k_reg);
      k_m1      = k_reg_ext - DIM_W'(1);
      kk        = 6'(k_reg) * 6'(k_reg);
      cfg_ok    = (cfg_k != 3'd0) && (cfg_k <= 3'(K_MAX)) &&
                  (k_in_ext <= cfg_w) && (k_in_ext <= cfg_h);
      // abort wins over a simultaneous start
      accept    = (state == StIdle) && start && cfg_ok && !abort;
      hs        = (state == StStream) && px_valid;
      last_col  = (col == w_reg - DIM_W'(1));
      last_px   = hs && last_col && (row == h_reg - DIM_W'(1));
      win_ok    = (row >= k_m1) && (col >= k_m1);
      wload_end = ({1'b0, widx} == kk - 6'd1);
      drain_end = (drain_cnt == DCW'(PIPE_LAT - 1));
   end

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= StIdle;
      end else begin
         state <= state_next;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next = state;
      unique case (state)
         StIdle:   if (accept) state_next = StWclr;
         StWclr:   state_next = StWload;
         StWload:  if (wload_end) state_next = StStream;
         StStream: if (last_px) state_next = StDrain;
         StDrain:  if (drain_end) state_next = StDone;
         StDone:   state_next = StIdle;
         default:  state_next = StIdle;
      endcase
      if (abort) begin
         state_next = StIdle;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      busy      = (state != StIdle);
      done      = (state == StDone);
      pe_rst_w  = (state == StWclr);
      w_ld      = (state == StWload);
      w_idx     = (state == StWload) ? widx : 5'd0;
      px_ready  = (state == StStream);
      cfg_err   = cfg_err_reg;
      pe_sel    = SEL_HOLD;
      if (hs) begin
         if (col != '0) begin
            pe_sel = SEL_SHIFT;
         end else if (row == '0) begin
            pe_sel = SEL_LOAD;
         end else begin
            pe_sel = SEL_WRAP;
         end
      end
      win_valid = dly_v[PIPE_LAT-1];
      win_row   = dly_row[PIPE_LAT-1];
      win_col   = dly_col[PIPE_LAT-1];
`ifdef PE_CTRL_PERF_EN
      stall_cnt = stall_reg;
`endif
   end

   // ---------------------------------------------------------------------------
   // Datapath: config latch, counters, window delay line
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST || abort) begin
         k_reg       <= '0;
         w_reg       <= '0;
         h_reg       <= '0;
         row         <= '0;
         col         <= '0;
         widx        <= '0;
         drain_cnt   <= '0;
         cfg_err_reg <= 1'b0;
         for (int unsigned i = 0; i < PIPE_LAT; i++) begin
            dly_v[i]   <= 1'b0;
            dly_row[i] <= '0;
            dly_col[i] <= '0;
         end
`ifdef PE_CTRL_PERF_EN
         stall_reg   <= '0;
`endif
      end else begin
         cfg_err_reg <= (state == StIdle) && start && !cfg_ok;

         if (accept) begin
            k_reg     <= cfg_k;
            w_reg     <= cfg_w;
            h_reg     <= cfg_h;
            row       <= '0;
            col       <= '0;
            widx      <= '0;
            drain_cnt <= '0;
`ifdef PE_CTRL_PERF_EN
            stall_reg <= '0;
`endif
         end

         if (state == StWload) begin
            widx <= wload_end ? 5'd0 : widx + 5'd1;
         end

         if (hs) begin
            if (last_col) begin
               col <= '0;
               row <= row + DIM_W'(1);
            end else begin
               col <= col + DIM_W'(1);
            end
         end

         if (state == StDrain) begin
            drain_cnt <= drain_cnt + DCW'(1);
         end

         // Stage 0 captures the handshake; bubbles travel down as zeros
         dly_v[0]   <= hs && win_ok;
         dly_row[0] <= (hs && win_ok) ? row - k_m1 : '0;
         dly_col[0] <= (hs && win_ok) ? col - k_m1 : '0;
         for (int unsigned i = 1; i < PIPE_LAT; i++) begin
            dly_v[i]   <= dly_v[i-1];
            dly_row[i] <= dly_row[i-1];
            dly_col[i] <= dly_col[i-1];
         end

`ifdef PE_CTRL_PERF_EN
         if ((state == StStream) && !px_valid && (stall_reg != 16'hFFFF)) begin
            stall_reg <= stall_reg + 16'd1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_pe_array_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pe_array_ctrl
//   Self-checking bench for pe_array_ctrl. Expected behaviour of each pass is
//   derived from the pass timeline (1 clear cycle, K*K load cycles, one pixel
//   per accepted cycle in raster order, PIPE_LAT drain cycles, 1 done cycle)
//   and the window rule, using plain arithmetic on the pixel index.
// -----------------------------------------------------------------------------
module tb_pe_array_ctrl;

   localparam int K_MAX    = 5;
   localparam int DIM_W    = 7;
   localparam int PIPE_LAT = 1;

   logic             CLK = 1'b0;
   logic             RST;
   logic             start;
   logic             abort;
   logic [2:0]       cfg_k;
   logic [DIM_W-1:0] cfg_w;
   logic [DIM_W-1:0] cfg_h;
   logic             busy;
   logic             done;
   logic             cfg_err;
   logic             pe_rst_w;
   logic             w_ld;
   logic [4:0]       w_idx;
   logic             px_valid;
   logic             px_ready;
   logic [1:0]       pe_sel;
   logic             win_valid;
   logic [DIM_W-1:0] win_row;
   logic [DIM_W-1:0] win_col;
`ifdef PE_CTRL_PERF_EN
   logic [15:0]      stall_cnt;
`endif

   int total = 0;
   int bad   = 0;

   // Windows expected at the adder-tree output: due cycle and coordinates
   int q_due[$];
   int q_row[$];
   int q_col[$];

   always #5 CLK = ~CLK;

   pe_array_ctrl #(
      .K_MAX    (K_MAX),
      .DIM_W    (DIM_W),
      .PIPE_LAT (PIPE_LAT)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .start     (start),
      .abort     (abort),
      .cfg_k     (cfg_k),
      .cfg_w     (cfg_w),
      .cfg_h     (cfg_h),
      .busy      (busy),
      .done      (done),
      .cfg_err   (cfg_err),
      .pe_rst_w  (pe_rst_w),
      .w_ld      (w_ld),
      .w_idx     (w_idx),
      .px_valid  (px_valid),
      .px_ready  (px_ready),
      .pe_sel    (pe_sel),
      .win_valid (win_valid),
      .win_row   (win_row),
`ifdef PE_CTRL_PERF_EN
      .stall_cnt (stall_cnt),
`endif
      .win_col   (win_col)
   );

   task automatic check_eq(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got=%0d want=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance to the next drive point (just after the rising edge)
   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   // Every output at its reset value
   task automatic check_all_zero(input string pfx);
      check_eq({pfx, "_busy"},     32'(busy),      0);
      check_eq({pfx, "_done"},     32'(done),      0);
      check_eq({pfx, "_cfg_err"},  32'(cfg_err),   0);
      check_eq({pfx, "_pe_rst_w"}, 32'(pe_rst_w),  0);
      check_eq({pfx, "_w_ld"},     32'(w_ld),      0);
      check_eq({pfx, "_w_idx"},    32'(w_idx),     0);
      check_eq({pfx, "_px_ready"}, 32'(px_ready),  0);
      check_eq({pfx, "_pe_sel"},   32'(pe_sel),    0);
      check_eq({pfx, "_win_v"},    32'(win_valid), 0);
      check_eq({pfx, "_win_row"},  32'(win_row),   0);
      check_eq({pfx, "_win_col"},  32'(win_col),   0);
   endtask

   task automatic check_win(input int cyc);
      if (q_due.size() > 0 && q_due[0] == cyc) begin
         check_eq("win_valid", 32'(win_valid), 1);
         check_eq("win_row",   32'(win_row),   q_row[0]);
         check_eq("win_col",   32'(win_col),   q_col[0]);
         void'(q_due.pop_front());
         void'(q_row.pop_front());
         void'(q_col.pop_front());
      end else begin
         check_eq("win_quiet", 32'(win_valid), 0);
      end
   endtask

   // mode 0: px_valid always high; 1: low on even stream cycles; 2: random.
   // abort_at >= 0 raises abort together with that pixel's handshake.
   task automatic run_pass(input int k, input int w, input int h,
                           input int mode, input int abort_at);
      int p;
      int cyc;
      int stalls;
      int r;
      int c;
      int exp_sel;
      bit pv;
      bit ab;
      q_due.delete();
      q_row.delete();
      q_col.delete();

      cfg_k = 3'(k);
      cfg_w = DIM_W'(w);
      cfg_h = DIM_W'(h);
      start = 1'b1;
      @(negedge CLK);
      check_eq("start_idle_busy", 32'(busy), 0);
      next_cycle();
      start = 1'b0;

      @(negedge CLK);
      check_eq("wclr_pe_rst_w", 32'(pe_rst_w), 1);
      check_eq("wclr_busy",     32'(busy),     1);
      check_eq("wclr_w_ld",     32'(w_ld),     0);
      next_cycle();

      for (int i = 0; i < k * k; i++) begin
         @(negedge CLK);
         check_eq("wload_w_ld",     32'(w_ld),     1);
         check_eq("wload_w_idx",    32'(w_idx),    i);
         check_eq("wload_pe_rst_w", 32'(pe_rst_w), 0);
         check_eq("wload_px_ready", 32'(px_ready), 0);
         next_cycle();
      end

      p      = 0;
      cyc    = 0;
      stalls = 0;
      while (p < w * h) begin
         case (mode)
            0:       pv = 1'b1;
            1:       pv = (cyc % 2) == 1;
            default: pv = ($urandom_range(0, 3) != 0);
         endcase
         ab       = pv && (p == abort_at);
         px_valid = pv;
         abort    = ab;
         @(negedge CLK);
         check_eq("stream_px_ready", 32'(px_ready), 1);
         check_eq("stream_busy",     32'(busy),     1);
         r = p / w;
         c = p % w;
         if (!pv)                  exp_sel = 0;
         else if (p == 0)          exp_sel = 2;
         else if (c == 0)          exp_sel = 3;
         else                      exp_sel = 1;
         check_eq("stream_pe_sel", 32'(pe_sel), exp_sel);
         check_win(cyc);
         if (!pv) begin
            stalls++;
         end else begin
            if (r >= k - 1 && c >= k - 1) begin
               q_due.push_back(cyc + PIPE_LAT);
               q_row.push_back(r - (k - 1));
               q_col.push_back(c - (k - 1));
            end
            p++;
         end
         cyc++;
         next_cycle();
         px_valid = 1'b0;
         abort    = 1'b0;
         if (ab) begin
            @(negedge CLK);
            check_eq("abort_busy",     32'(busy),      0);
            check_eq("abort_px_ready", 32'(px_ready),  0);
            check_eq("abort_win_v",    32'(win_valid), 0);
            check_eq("abort_done",     32'(done),      0);
            next_cycle();
            for (int i = 0; i < 4; i++) begin
               @(negedge CLK);
               check_eq("post_abort_done", 32'(done), 0);
               check_eq("post_abort_busy", 32'(busy), 0);
               next_cycle();
            end
            return;
         end
      end

      for (int i = 0; i < PIPE_LAT; i++) begin
         @(negedge CLK);
         check_eq("drain_px_ready", 32'(px_ready), 0);
         check_eq("drain_done",     32'(done),     0);
         check_eq("drain_busy",     32'(busy),     1);
         check_eq("drain_pe_sel",   32'(pe_sel),   0);
         check_win(cyc);
         cyc++;
         next_cycle();
      end

      @(negedge CLK);
      check_eq("done_pulse",    32'(done),      1);
      check_eq("done_busy",     32'(busy),      1);
      check_eq("done_win_v",    32'(win_valid), 0);
      check_eq("windows_left",  q_due.size(),   0);
      next_cycle();

      @(negedge CLK);
      check_eq("after_done",      32'(done), 0);
      check_eq("after_done_busy", 32'(busy), 0);
`ifdef PE_CTRL_PERF_EN
      check_eq("stall_cnt", 32'(stall_cnt), stalls);
`else
      stalls = stalls;
`endif
      next_cycle();
   endtask

   initial begin
      int k;
      int w;
      int h;

      RST      = 1'b1;
      start    = 1'b0;
      abort    = 1'b0;
      px_valid = 1'b0;
      cfg_k    = '0;
      cfg_w    = '0;
      cfg_h    = '0;
      next_cycle();
      next_cycle();
      @(negedge CLK);
      check_all_zero("reset");
      next_cycle();
      RST = 1'b0;
      next_cycle();

      // Directed passes
      run_pass(3, 4, 4, 0, -1);
      run_pass(3, 4, 4, 1, -1);
      run_pass(1, 2, 2, 0, -1);

      // Rejected configuration: K larger than W
      cfg_k = 3'd4;
      cfg_w = DIM_W'(3);
      cfg_h = DIM_W'(8);
      start = 1'b1;
      next_cycle();
      start = 1'b0;
      @(negedge CLK);
      check_eq("bad_cfg_err",      32'(cfg_err),  1);
      check_eq("bad_cfg_busy",     32'(busy),     0);
      check_eq("bad_cfg_pe_rst_w", 32'(pe_rst_w), 0);
      next_cycle();
      @(negedge CLK);
      check_eq("bad_cfg_err_end", 32'(cfg_err),  0);
      check_eq("bad_cfg_busy2",   32'(busy),     0);
      check_eq("bad_cfg_no_clr",  32'(pe_rst_w), 0);
      next_cycle();

      // K=0 also rejected
      cfg_k = 3'd0;
      cfg_w = DIM_W'(4);
      cfg_h = DIM_W'(4);
      start = 1'b1;
      next_cycle();
      start = 1'b0;
      @(negedge CLK);
      check_eq("k0_cfg_err", 32'(cfg_err), 1);
      check_eq("k0_busy",    32'(busy),    0);
      next_cycle();

      // Abort on the 5th handshake, then a clean pass
      run_pass(3, 4, 4, 0, 4);
      run_pass(3, 4, 4, 0, -1);

      // RST in the middle of the weight load
      cfg_k = 3'd3;
      cfg_w = DIM_W'(4);
      cfg_h = DIM_W'(4);
      start = 1'b1;
      next_cycle();
      start = 1'b0;
      repeat (4) next_cycle();
      @(negedge CLK);
      check_eq("pre_rst_w_ld", 32'(w_ld), 1);
      next_cycle();
      RST = 1'b1;
      next_cycle();
      RST = 1'b0;
      @(negedge CLK);
      check_all_zero("mid_rst");
      next_cycle();

      // start together with abort stays in IDLE
      start = 1'b1;
      abort = 1'b1;
      next_cycle();
      start = 1'b0;
      abort = 1'b0;
      @(negedge CLK);
      check_eq("start_abort_busy",  32'(busy),     0);
      check_eq("start_abort_clr",   32'(pe_rst_w), 0);
      check_eq("start_abort_cferr", 32'(cfg_err),  0);
      next_cycle();

      // Randomised passes
      for (int n = 0; n < 8; n++) begin
         k = $urandom_range(1, K_MAX);
         w = $urandom_range(k, k + 4);
         h = $urandom_range(k, k + 3);
         run_pass(k, w, h, 2, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute time guard so the run always ends
   initial begin
      #2000000;
      $display("FAIL timeout: got=running want=finished");
      $fatal(1, "timeout");
   end

endmodule
